// File: rtl/ysyx_22041752_div_pkg.sv
// ysyx_22041752_div_pkg: shared widths, iteration counts and FSM encoding for the divider
// Build option: YSYX_22041752_DIV_FAST_EXC_EN (used in the top) makes divide-by-zero/overflow finish in one cycle.
package ysyx_22041752_div_pkg;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  localparam int XLEN = 64;
  localparam int WLEN = 32;
  localparam int CNT_W = 7;
  localparam logic [CNT_W-1:0] ITER_D = 7'd64;
  localparam logic [CNT_W-1:0] ITER_W = 7'd32;
  function automatic logic [XLEN-1:0] sext_w(input logic [WLEN-1:0] v);
    return {{(XLEN-WLEN){v[WLEN-1]}}, v};
  endfunction
endpackage

// File: rtl/ysyx_22041752_divider_if.sv
// ysyx_22041752_divider_if: request/result handshake bundle of the divider
// master: drives div_valid, div_signed, div_word, dividend, divisor, flush, out_ready
// slave:  drives div_ready, out_valid, quotient, remainder
interface ysyx_22041752_divider_if;
  import ysyx_22041752_div_pkg::*;
  logic            div_valid;
  logic            div_ready;
  logic            div_signed;
  logic            div_word;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] quotient;
  logic [XLEN-1:0] remainder;
  modport master (
    output div_valid, div_signed, div_word, dividend, divisor, flush, out_ready,
    input  div_ready, out_valid, quotient, remainder
  );
  modport slave (
    input  div_valid, div_signed, div_word, dividend, divisor, flush, out_ready,
    output div_ready, out_valid, quotient, remainder
  );
endinterface

// File: rtl/ysyx_22041752_div_step.sv
// ysyx_22041752_div_step: one restoring-division iteration on magnitudes
// i_rem: partial remainder, i_a_msb: next dividend bit, i_b: divisor magnitude
// o_rem: next partial remainder, o_q: quotient bit
module ysyx_22041752_div_step
  import ysyx_22041752_div_pkg::*;
(
  input  logic [XLEN-1:0] i_rem,
  input  logic            i_a_msb,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_rem,
  output logic            o_q
);
  logic [XLEN-1:0] w_low, w_diff;
  // the shifted remainder is 65 bits; its top bit alone guarantees the subtract succeeds,
  // and the true difference is below i_b so the low 64 bits of the wrapped subtract are exact
  assign w_low  = {i_rem[XLEN-2:0], i_a_msb};
  assign w_diff = w_low - i_b;
  assign o_q    = i_rem[XLEN-1] | (w_low >= i_b);
  assign o_rem  = o_q ? w_diff : w_low;
endmodule

// File: rtl/ysyx_22041752_divider.sv
// ysyx_22041752_divider: RV64 DIV/DIVU/REM/REMU (+W forms) radix-2 restoring divider
// clk: rising-edge clock, rst_n: async active-low reset, bus: slave side of ysyx_22041752_divider_if
// Build option: YSYX_22041752_DIV_FAST_EXC_EN sends divide-by-zero and signed overflow straight to DONE.
module ysyx_22041752_divider
  import ysyx_22041752_div_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  ysyx_22041752_divider_if.slave        bus
);
  state_t           r_state, w_next;
  logic             r_live, r_word, r_neg_q, r_neg_r, r_div0, r_ovf;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_a, r_b, r_rem, r_a_ext;
  logic [XLEN-1:0]  w_a_ext, w_b_ext, w_a_mag, w_b_mag, w_min, w_rem_nxt, w_q_fix, w_r_fix, w_q_sel, w_r_sel;
  logic             w_a_neg, w_b_neg, w_div0, w_ovf, w_fast, w_accept, w_q_bit;
  always_comb begin
    w_a_ext = bus.div_word ? {{(XLEN-WLEN){bus.div_signed & bus.dividend[WLEN-1]}}, bus.dividend[WLEN-1:0]} : bus.dividend;
    w_b_ext = bus.div_word ? {{(XLEN-WLEN){bus.div_signed & bus.divisor[WLEN-1]}}, bus.divisor[WLEN-1:0]} : bus.divisor;
    w_a_neg = bus.div_signed & w_a_ext[XLEN-1];
    w_b_neg = bus.div_signed & w_b_ext[XLEN-1];
    w_a_mag = w_a_neg ? -w_a_ext : w_a_ext;
    w_b_mag = w_b_neg ? -w_b_ext : w_b_ext;
    w_min   = bus.div_word ? {{(XLEN-WLEN+1){1'b1}}, {(WLEN-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    w_div0  = w_b_ext == '0;
    w_ovf   = bus.div_signed && w_b_ext == '1 && w_a_ext == w_min;
`ifdef YSYX_22041752_DIV_FAST_EXC_EN
    w_fast  = w_div0 | w_ovf;
`else
    w_fast  = 1'b0;
`endif
  end
  assign bus.div_ready = r_live && r_state == S_IDLE;
  assign w_accept = bus.div_valid && bus.div_ready && !bus.flush;
  always_comb begin
    w_next = r_state;
    if (bus.flush) w_next = S_IDLE;
    else if (w_accept) w_next = w_fast ? S_DONE : S_BUSY;
    else if (r_state == S_BUSY && r_cnt == CNT_W'(1)) w_next = S_DONE;
    else if (r_state == S_DONE && bus.out_ready) w_next = S_IDLE;
  end
  ysyx_22041752_div_step u_step (
    .i_rem   (r_rem),
    .i_a_msb (r_a[XLEN-1]),
    .i_b     (r_b),
    .o_rem   (w_rem_nxt),
    .o_q     (w_q_bit)
  );
  // r_a shifts dividend bits out of the top and quotient bits in at the bottom;
  // word operands start left-aligned so 32 shifts leave the quotient in [31:0]
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_live  <= 1'b0;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_rem   <= '0;
      r_a_ext <= '0;
      r_word  <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_div0  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_live  <= 1'b1;
      if (w_accept) begin
        r_a     <= bus.div_word ? {w_a_mag[WLEN-1:0], {(XLEN-WLEN){1'b0}}} : w_a_mag;
        r_b     <= w_b_mag;
        r_rem   <= '0;
        r_a_ext <= w_a_ext;
        r_cnt   <= bus.div_word ? ITER_W : ITER_D;
        r_word  <= bus.div_word;
        r_neg_q <= w_a_neg ^ w_b_neg;
        r_neg_r <= w_a_neg;
        r_div0  <= w_div0;
        r_ovf   <= w_ovf;
      end else if (r_state == S_BUSY) begin
        r_a   <= {r_a[XLEN-2:0], w_q_bit};
        r_rem <= w_rem_nxt;
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end
  always_comb begin
    w_q_fix = r_neg_q ? -r_a : r_a;
    w_r_fix = r_neg_r ? -r_rem : r_rem;
    w_q_sel = r_div0 ? '1 : r_ovf ? r_a_ext : w_q_fix;
    w_r_sel = r_div0 ? r_a_ext : r_ovf ? '0 : w_r_fix;
  end
  assign bus.out_valid = r_state == S_DONE;
  assign bus.quotient  = bus.out_valid ? (r_word ? sext_w(w_q_sel[WLEN-1:0]) : w_q_sel) : '0;
  assign bus.remainder = bus.out_valid ? (r_word ? sext_w(w_r_sel[WLEN-1:0]) : w_r_sel) : '0;
endmodule

// File: tb/tb_ysyx_22041752_divider.sv
// tb_ysyx_22041752_divider: randomized + directed bench against an arithmetic reference model
module tb_ysyx_22041752_divider;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  ysyx_22041752_divider_if bus ();
  ysyx_22041752_divider dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`ifdef YSYX_22041752_DIV_FAST_EXC_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  int checks = 0;
  int failures = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%h required=0x%h t=%0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [63:0] sx(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction
  function automatic bit special(input logic [63:0] a, input logic [63:0] b, input bit s, input bit w);
    if (w) return b[31:0] == 0 || (s && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
    return b == 0 || (s && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF);
  endfunction
  function automatic logic [127:0] ref_div(input logic [63:0] a, input logic [63:0] b, input bit s, input bit w);
    logic [63:0] q, r;
    logic signed [31:0] sa32, sb32;
    logic signed [63:0] sa, sb;
    sa32 = a[31:0];
    sb32 = b[31:0];
    sa = a;
    sb = b;
    if (w) begin
      if (b[31:0] == 0) begin q = '1; r = sx(a[31:0]); end
      else if (special(a, b, s, w)) begin q = sx(a[31:0]); r = '0; end
      else if (s) begin q = sx(32'(sa32 / sb32)); r = sx(32'(sa32 % sb32)); end
      else begin q = sx(a[31:0] / b[31:0]); r = sx(a[31:0] % b[31:0]); end
    end else begin
      if (b == 0) begin q = '1; r = a; end
      else if (special(a, b, s, w)) begin q = a; r = '0; end
      else if (s) begin q = 64'(sa / sb); r = 64'(sa % sb); end
      else begin q = a / b; r = a % b; end
    end
    return {q, r};
  endfunction
  // reference: a request accepted when idle produces its result after a fixed latency,
  // holds it until consumed, and is dropped by flush or reset
  logic [63:0]  m_q = '0, m_r = '0;
  int           m_left = -1;
  bit           m_out = 1'b0, m_live = 1'b0;
  wire          m_ready = m_live && (m_left < 0) && !m_out;
  wire [127:0]  m_calc = ref_div(bus.dividend, bus.divisor, bus.div_signed, bus.div_word);
  int           m_lat;
  assign m_lat = (FAST && special(bus.dividend, bus.divisor, bus.div_signed, bus.div_word)) ? 1 : (bus.div_word ? 33 : 65);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= -1;
      m_out  <= 1'b0;
      m_live <= 1'b0;
    end else begin
      m_live <= 1'b1;
      if (bus.flush) begin
        m_left <= -1;
        m_out  <= 1'b0;
      end else if (m_out) m_out <= !bus.out_ready;
      else if (m_left > 1) m_left <= m_left - 1;
      else if (m_left == 1) begin
        m_left <= -1;
        m_out  <= 1'b1;
      end else if (m_ready && bus.div_valid) begin
        m_q <= m_calc[127:64];
        m_r <= m_calc[63:0];
        if (m_lat == 1) m_out <= 1'b1;
        else m_left <= m_lat - 1;
      end
    end
  end
  always @(negedge clk) begin
    chk("div_ready", 64'(bus.div_ready), 64'(m_ready));
    chk("out_valid", 64'(bus.out_valid), 64'(m_out));
    chk("quotient", bus.quotient, m_out ? m_q : 64'h0);
    chk("remainder", bus.remainder, m_out ? m_r : 64'h0);
  end
  task automatic step_clk;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [63:0] a, input logic [63:0] b, input bit s, input bit w);
    int n;
    bus.dividend = a;
    bus.divisor = b;
    bus.div_signed = s;
    bus.div_word = w;
    bus.div_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.div_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("send_timeout", 64'(n), 64'd0);
    step_clk;
    bus.div_valid = 1'b0;
  endtask
  task automatic op(input string name, input logic [63:0] a, input logic [63:0] b, input bit s, input bit w,
                    input logic [63:0] eq, input logic [63:0] er, input int elat);
    int n;
    send(a, b, s, w);
    n = 1;
    while (!bus.out_valid && n < 200) begin
      step_clk;
      n++;
    end
    chk({name, "_lat"}, 64'(n), 64'(elat));
    chk({name, "_q"}, bus.quotient, eq);
    chk({name, "_r"}, bus.remainder, er);
  endtask
  task automatic rand_ops(output logic [63:0] a, output logic [63:0] b, input bit w);
    int mode;
    mode = $urandom_range(0, 7);
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    case (mode)
      0: b = w ? {b[63:32], 32'h0} : 64'h0;
      1: begin
        a = w ? {a[63:32], 32'h8000_0000} : 64'h8000_0000_0000_0000;
        b = w ? {b[63:32], 32'hFFFF_FFFF} : 64'hFFFF_FFFF_FFFF_FFFF;
      end
      2: b = 64'($urandom_range(1, 15));
      3: a = 64'($urandom_range(0, 1000));
      default: ;
    endcase
  endtask
  logic [127:0] t;
  logic [63:0]  ra, rb;
  bit           seen;
  initial begin
    bus.div_valid = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    bus.dividend = '0;
    bus.divisor = '0;
    bus.div_signed = 1'b0;
    bus.div_word = 1'b0;
    t = ref_div(64'd100, 64'd7, 1'b0, 1'b0);
    chk("model_100_7", t[127:64] ^ (t[63:0] << 8), 64'd14 ^ (64'd2 << 8));
    t = ref_div(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0);
    chk("model_m7_2_q", t[127:64], 64'hFFFF_FFFF_FFFF_FFFD);
    chk("model_m7_2_r", t[63:0], 64'hFFFF_FFFF_FFFF_FFFF);
    t = ref_div(64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 1'b1);
    chk("model_wovf_q", t[127:64], 64'hFFFF_FFFF_8000_0000);
    repeat (3) step_clk;
    chk("rst_ready", 64'(bus.div_ready), 64'd0);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    rst_n = 1'b1;
    step_clk;
    chk("ready_after_rst", 64'(bus.div_ready), 64'd1);
    op("udiv", 64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 64'd2, 65);
    op("sdiv", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    op("wudiv", 64'h0000_0000_FFFF_FFFE, 64'd1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 33);
    op("div0", 64'h1234, 64'd0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, FAST ? 1 : 65);
    op("sovf", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'd0, FAST ? 1 : 65);
    op("wovf", 64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd0, FAST ? 1 : 33);
    send(64'd100, 64'd7, 1'b0, 1'b0);
    repeat (19) step_clk;
    bus.flush = 1'b1;
    step_clk;
    bus.flush = 1'b0;
    chk("flush_ready", 64'(bus.div_ready), 64'd1);
    chk("flush_valid", 64'(bus.out_valid), 64'd0);
    bus.div_valid = 1'b1;
    bus.flush = 1'b1;
    step_clk;
    bus.div_valid = 1'b0;
    bus.flush = 1'b0;
    chk("flush_wins_ready", 64'(bus.div_ready), 64'd1);
    bus.out_ready = 1'b0;
    op("hold", 64'd9, 64'd4, 1'b0, 1'b0, 64'd2, 64'd1, 65);
    repeat (10) begin
      step_clk;
      chk("hold_valid", 64'(bus.out_valid), 64'd1);
      chk("hold_q", bus.quotient, 64'd2);
      chk("hold_r", bus.remainder, 64'd1);
    end
    bus.out_ready = 1'b1;
    step_clk;
    chk("hold_release", 64'(bus.out_valid), 64'd0);
    send(64'd100, 64'd7, 1'b0, 1'b0);
    repeat (9) step_clk;
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 64'(bus.div_ready), 64'd0);
    chk("midrst_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_q", bus.quotient, 64'd0);
    chk("midrst_r", bus.remainder, 64'd0);
    repeat (2) step_clk;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (80) begin
      step_clk;
      if (bus.out_valid) seen = 1'b1;
    end
    chk("midrst_no_result", 64'(seen), 64'd0);
    repeat (4000) begin
      bus.div_word = 1'($urandom_range(0, 1));
      bus.div_signed = 1'($urandom_range(0, 1));
      rand_ops(ra, rb, bus.div_word);
      bus.dividend = ra;
      bus.divisor = rb;
      bus.div_valid = $urandom_range(0, 3) != 0;
      bus.flush = $urandom_range(0, 299) == 0;
      bus.out_ready = $urandom_range(0, 2) != 0;
      step_clk;
    end
    bus.div_valid = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) step_clk;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ysyx_22041752_divider.md
YSYX_22041752_DIVIDER -- requirements
Module: ysyx_22041752_divider

Interface
REQ-001 SHALL provide: clk  in  1  sole clock, rising-edge.
REQ-002 SHALL provide: rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-003 SHALL provide: div_valid  in  1  request valid.
REQ-004 SHALL provide: div_ready  out  1  divider can accept a request.
REQ-005 SHALL provide: div_signed  in  1  1 = DIV/REM, 0 = DIVU/REMU.
REQ-006 SHALL provide: div_word  in  1  1 = RV64 W-form, operands are [31:0].
REQ-007 SHALL provide: dividend  in  64  operand a.
REQ-008 SHALL provide: divisor  in  64  operand b.
REQ-009 SHALL provide: flush  in  1  abort the in-flight operation.
REQ-010 SHALL provide: out_valid  out  1  result valid.
REQ-011 SHALL provide: out_ready  in  1  consumer accepts result.
REQ-012 SHALL provide: quotient  out  64  quotient.
REQ-013 SHALL provide: remainder  out  64  remainder.

Function
REQ-014 SHALL implement FSM IDLE, BUSY, DONE.
- IDLE->BUSY on div_valid&&div_ready.
- BUSY->DONE after last iteration.
- DONE->IDLE on out_valid&&out_ready.
REQ-015 SHALL drive div_ready=1 only in IDLE. Operands, div_signed and div_word are captured in the accepting cycle.
REQ-016 SHALL use radix-2 restoring division on magnitudes: one quotient bit per cycle, 64 iterations (div_word=0) or 32 iterations (div_word=1).
REQ-017 SHALL count the accepting cycle as cycle 0. out_valid SHALL first rise in cycle 65 (doubleword) or cycle 33 (word).
REQ-018 SHALL hold out_valid, quotient and remainder stable in DONE until out_ready is high. A new request SHALL be accepted no earlier than the cycle after the handshake.
REQ-019 Signed mode: quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
REQ-020 Word mode:
- Operands are sign-extended (signed) or zero-extended (unsigned) from [31:0].
- Both results are bits [31:0] sign-extended to 64, including the unsigned case.
REQ-021 Divisor zero: quotient = all ones; remainder = dividend (word: sext(dividend[31:0])).
REQ-022 Signed overflow (most-negative / -1, at the active width): quotient = dividend at the active width; remainder = 0.
REQ-023 Flush in BUSY or DONE SHALL return to IDLE on the next edge, drop out_valid, and discard the result. Flush in IDLE SHALL have no effect.
REQ-024 Flush and div_valid in the same IDLE cycle: flush wins and no request is accepted.
REQ-025 quotient and remainder SHALL read 0 whenever out_valid=0.

Reset
REQ-026 rst_n low SHALL immediately force IDLE and clear the iteration counter and all datapath registers.
REQ-027 Output values while rst_n is low: div_ready=0, out_valid=0, quotient=0, remainder=0.
REQ-028 div_ready SHALL rise on the first edge after rst_n deasserts.
REQ-029 Reset mid-operation SHALL discard the operation; no result is ever presented for it.

Configuration
REQ-030 Macro YSYX_22041752_DIV_FAST_EXC_EN SHALL control the timing of divide-by-zero and signed-overflow requests.
- Defined: these requests go straight from IDLE to DONE; out_valid rises in cycle 1.
- Undefined: these requests take the full REQ-017 latency.
- Result values are identical in both builds.

Structure
REQ-031 Package ysyx_22041752_div_pkg SHALL hold:
- FSM state encoding.
- XLEN=64 and WLEN=32.
- Iteration-count constants and counter width (7 bits).
REQ-032 Sub-module ysyx_22041752_div_step SHALL implement one iteration combinationally: shift partial remainder, trial subtract, select quotient bit. The top SHALL hold the FSM, counter, sign fix-up and special-case muxing.

Verification
REQ-033 Unsigned 100/7, div_word=0, out_ready=1 -> quotient=14, remainder=2; out_valid rises in cycle 65.
REQ-034 Signed -7/2 (0xFFFF_FFFF_FFFF_FFF9 / 2) -> quotient=-3 (0x...FFFD), remainder=-1 (0x...FFFF).
REQ-035 Word unsigned, dividend=0x0000_0000_FFFF_FFFE, divisor=1 -> quotient=remainder-free result 0xFFFF_FFFF_FFFF_FFFE (sign-extended), remainder=0; out_valid rises in cycle 33.
REQ-036 Divisor=0, dividend=0x1234:
- Result: quotient=0xFFFF_FFFF_FFFF_FFFF, remainder=0x1234.
- Timing: out_valid rises in cycle 1 with the macro defined, cycle 65 without.
REQ-037 Signed 0x8000_0000_0000_0000 / -1 -> quotient=0x8000_0000_0000_0000, remainder=0. Word form of 0x8000_0000 / -1 -> quotient=0xFFFF_FFFF_8000_0000, remainder=0.
REQ-038 Start 100/7; assert flush in cycle 20 -> next cycle div_ready=1 and out_valid=0. Then hold out_ready=0 on a new 9/4 request -> quotient=2, remainder=1 held stable until out_ready=1. Pulse rst_n low in cycle 10 of a further request -> all outputs 0 and no result is presented.
